// File: rtl/alu_op_sequencer_if.sv
// Bus bundle between the ALU sequencer, its upstream producer, the external adder and the downstream consumer.
// slave is the sequencer's view; master is the surrounding environment's view.
interface alu_op_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_opA;
    logic [31:0] in_opB;
    logic [2:0]  in_command;
    logic [31:0] add_opA;
    logic [31:0] add_opB;
    logic [2:0]  add_command;
    logic [31:0] add_ans;
    logic        add_carryout;
    logic        add_overflow;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_carryout;
    logic        out_overflow;
    logic        out_zero;
    logic        out_negative;

    modport slave (
        input  in_valid, in_opA, in_opB, in_command,
        output in_ready,
        output add_opA, add_opB, add_command,
        input  add_ans, add_carryout, add_overflow,
        output out_valid, out_result, out_carryout, out_overflow, out_zero, out_negative,
        input  out_ready
    );

    modport master (
        output in_valid, in_opA, in_opB, in_command,
        input  in_ready,
        input  add_opA, add_opB, add_command,
        output add_ans, add_carryout, add_overflow,
        input  out_valid, out_result, out_carryout, out_overflow, out_zero, out_negative,
        output out_ready
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Registers one operation into an external ripple adder, waits SETTLE_CYCLES for it to resolve,
// then captures sum/carry/overflow plus zero/negative flags behind an output valid/ready handshake.
module alu_op_sequencer #(
    parameter int SETTLE_CYCLES = 8,
    parameter int CNT_W         = 8
) (
    input  logic              clk,
    input  logic              reset,
    alu_op_sequencer_if.slave bus
);

    localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_add_opA;
    logic [31:0]      r_add_opB;
    logic [2:0]       r_add_command;
    logic             r_out_valid;
    logic [31:0]      r_out_result;
    logic             r_out_carryout;
    logic             r_out_overflow;
    logic             r_out_zero;
    logic             r_out_negative;

    logic             w_in_ready;
    logic             w_load;

    // HOLD passes the downstream ready straight through so a retire and a new accept share one edge.
    assign w_in_ready = (r_state == S_IDLE) | ((r_state == S_HOLD) & bus.out_ready);
    assign w_load     = bus.in_valid & w_in_ready;

    // Sequencer state, settle counter, adder operand registers and captured result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_cnt          <= {CNT_W{1'b0}};
            r_add_opA      <= 32'd0;
            r_add_opB      <= 32'd0;
            r_add_command  <= 3'd0;
            r_out_valid    <= 1'b0;
            r_out_result   <= 32'd0;
            r_out_carryout <= 1'b0;
            r_out_overflow <= 1'b0;
            r_out_zero     <= 1'b0;
            r_out_negative <= 1'b0;
        end else begin
            if (w_load) begin
                r_add_opA     <= bus.in_opA;
                r_add_opB     <= bus.in_opB;
                r_add_command <= bus.in_command;
            end
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_cnt   <= C_CNT_LOAD;
                        r_state <= S_SETTLE;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == {CNT_W{1'b0}}) begin
                        // Flags come from the sampled sum so they never track a changing adder output.
                        r_out_result   <= bus.add_ans;
                        r_out_carryout <= bus.add_carryout;
                        r_out_overflow <= bus.add_overflow;
                        r_out_zero     <= (bus.add_ans == 32'd0);
                        r_out_negative <= bus.add_ans[31];
                        r_out_valid    <= 1'b1;
                        r_state        <= S_HOLD;
                    end else begin
                        r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                S_HOLD: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        if (bus.in_valid) begin
                            r_cnt   <= C_CNT_LOAD;
                            r_state <= S_SETTLE;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_state <= S_HOLD;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.add_opA      = r_add_opA;
    assign bus.add_opB      = r_add_opB;
    assign bus.add_command  = r_add_command;
    assign bus.out_valid    = r_out_valid;
    assign bus.out_result   = r_out_result;
    assign bus.out_carryout = r_out_carryout;
    assign bus.out_overflow = r_out_overflow;
    assign bus.out_zero     = r_out_zero;
    assign bus.out_negative = r_out_negative;

endmodule
